mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have clk  input  1  rising-edge system clock.
REQ-002 SHALL have rst_n  input  1  reset, synchronous, active-low; one clock domain only.
REQ-003 SHALL have instr  input  32  instruction register contents, valid from DECODE onward.
REQ-004 SHALL have mem_ready  input  1  memory completion strobe for the current mem_req.
REQ-005 SHALL have br_taken  input  1  ALU Q[0] during branch EXEC.
REQ-006 SHALL have mem_req  output  1  memory access request.
REQ-007 SHALL have mem_we  output  1  store qualifier for mem_req.
REQ-008 SHALL have ir_we  output  1  instruction register load.
REQ-009 SHALL have pc_we  output  1  PC update.
REQ-010 SHALL have pc_sel  output  2  next-PC select: 0 PC+4, 1 ALU Q, 2 trap vector.
REQ-011 SHALL have alu_a_sel  output  1  ALU A select: 0 rs1, 1 PC.
REQ-012 SHALL have alu_b_sel  output  1  ALU B select: 0 rs2, 1 immediate.
REQ-013 SHALL have alu_opcode, alu_func3  output  7, 3  ALU opcode and func3, copied from instr.
REQ-014 SHALL have alu_sub, alu_sra  output  1, 1  ALU mode bits, both = instr[30].
REQ-015 SHALL have rf_we  output  1  register-file write enable.
REQ-016 SHALL have wb_sel  output  2  writeback source: 0 ALU Q, 1 load data, 2 PC+4.
REQ-017 SHALL have illegal  output  1  sticky illegal-opcode flag.
REQ-018 SHALL have state  output  3  current FSM state, for debug.

Function
REQ-019 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-020 FETCH SHALL assert mem_req=1 and mem_we=0 and hold them until mem_ready; in the mem_ready cycle it SHALL assert ir_we=1, pc_we=1 and pc_sel=0, then go to DECODE.
REQ-021 DECODE SHALL last one cycle.
- Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- Legal opcode -> EXEC.
- Any other opcode -> TRAP.
REQ-022 EXEC SHALL last one cycle and drive the ALU from instr.
- alu_a_sel=1 for AUIPC and JAL.
- alu_b_sel=1 for every opcode except OP and BRANCH.
REQ-023 EXEC next state:
- LOAD/STORE -> MEM.
- BRANCH -> FETCH; pc_we=br_taken, pc_sel=1.
- JAL/JALR -> WB; pc_we=1, pc_sel=1.
- All other opcodes -> WB.
REQ-024 MEM SHALL hold mem_req=1, with mem_we=1 for STORE, until mem_ready.
- LOAD then -> WB.
- STORE then -> FETCH.
REQ-025 WB SHALL assert rf_we=1 for exactly one cycle, then go to FETCH.
- wb_sel=1 for LOAD, 2 for JAL/JALR, 0 otherwise.
- rf_we SHALL be suppressed when instr[11:7]=0.
REQ-026 TRAP SHALL set illegal=1, pulse pc_we=1 with pc_sel=2 for one cycle, then go to FETCH.
REQ-027 All strobes (ir_we, pc_we, rf_we, mem_req) SHALL be Moore/registered-state decoded.
- Each SHALL be 0 in every state not listed above.
- No strobe SHALL be asserted for two instructions in the same cycle.
REQ-028 mem_ready while mem_req=0 SHALL be ignored.
REQ-029 mem_ready in the first cycle of FETCH/MEM SHALL complete the access in that same cycle (zero-wait memory gives FETCH latency 1).
REQ-030 Instruction latency with zero-wait memory SHALL be:
- ALU and jump instructions: 4 cycles.
- Branches: 3 cycles.
- Loads: 5 cycles.
- Stores: 4 cycles.

Reset
REQ-031 When rst_n=0 at a rising clk edge, the FSM SHALL enter FETCH.
- illegal SHALL be cleared.
- All strobes SHALL be 0 in the following cycle.
REQ-032 Reset asserted mid-access SHALL abandon the access; mem_req SHALL drop the cycle after the reset edge.
REQ-033 illegal SHALL clear only on reset.

Configuration
REQ-034 With macro MC_CONTROL_INSTRET_EN defined, the block SHALL add an output instret (32 bits).
- Reset value 0.
- Increments by 1 on each transition into FETCH from WB, MEM (store) or EXEC (branch).
- Not incremented by TRAP.
- Wraps from 0xFFFFFFFF to 0.
REQ-035 Without MC_CONTROL_INSTRET_EN, the port and counter SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-036 A shared package mc_pkg SHALL hold:
- State encodings.
- The 7-bit opcode constants.
- pc_sel and wb_sel encodings.
REQ-037 One sub-module, mc_decode, SHALL hold the combinational opcode classification (legal, is_load, is_store, is_branch, is_jump, uses_imm, uses_pc); mc_control SHALL hold the FSM and registers.

Verification
REQ-038 ADDI x1,x0,5 (0x00500093), mem_ready=1 always -> states FETCH,DECODE,EXEC,WB; rf_we=1 in cycle 4, wb_sel=0, alu_b_sel=1.
REQ-039 LW with mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles, mem_we=0, then WB with wb_sel=1; total 8 cycles.
REQ-040 BEQ (0x00208463) with br_taken=1 -> pc_we=1, pc_sel=1 in EXEC, no rf_we; with br_taken=0 -> pc_we=0 in EXEC.
REQ-041 Opcode 0x7F -> TRAP, illegal=1, pc_sel=2 pulse, illegal remains 1 through following instructions until rst_n=0.
REQ-042 rst_n=0 asserted during MEM of SW -> next cycle state=FETCH, mem_req=0, mem_we=0; with MC_CONTROL_INSTRET_EN, instret=0 and reaches 3 after three completed ADDIs.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, RV32I major
// opcodes, and the next-PC / writeback mux selects.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SEL_ALU   = 2'd1;
    localparam logic [1:0] PC_SEL_TRAP  = 2'd2;

    localparam logic [1:0] WB_SEL_ALU   = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD  = 2'd1;
    localparam logic [1:0] WB_SEL_PC4   = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode classification used by the controller FSM and the
// ALU operand selects.
module mc_decode
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       legal,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jump,
    output logic       uses_imm,
    output logic       uses_pc
);

    always_comb begin
        legal = 1'b1;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: legal = 1'b1;
            default:                                 legal = 1'b0;
        endcase
    end

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);
    assign uses_pc   = (opcode == OPC_AUIPC) || (opcode == OPC_JAL);
    // Everything except register-register ALU ops and compares takes the immediate.
    assign uses_imm  = legal && (opcode != OPC_OP) && (opcode != OPC_BRANCH);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Optional retired-instruction counter under MC_CONTROL_INSTRET_EN.
module mc_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [6:0]  alu_opcode,
    output logic [2:0]  alu_func3,
    output logic        alu_sub,
    output logic        alu_sra,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [2:0]  state
`ifdef MC_CONTROL_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    state_t cur_st, nxt_st;
    logic   boot_q;
    logic   legal, is_load, is_store, is_branch, is_jump, uses_imm, uses_pc;
    logic   unused_instr_bits;

    mc_decode u_decode (
        .opcode    (instr[6:0]),
        .legal     (legal),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .uses_imm  (uses_imm),
        .uses_pc   (uses_pc)
    );

    assign alu_opcode        = instr[6:0];
    assign alu_func3         = instr[14:12];
    assign alu_sub           = instr[30];
    assign alu_sra           = instr[30];
    assign alu_a_sel         = uses_pc;
    assign alu_b_sel         = uses_imm;
    assign state             = cur_st;
    assign unused_instr_bits = ^{instr[31], instr[29:15]};

    // boot_q holds every strobe low for the first cycle after reset so an
    // access that was in flight at the reset edge is dropped cleanly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_st  <= ST_FETCH;
            boot_q  <= 1'b1;
            illegal <= 1'b0;
        end else begin
            cur_st  <= nxt_st;
            boot_q  <= 1'b0;
            if (nxt_st == ST_TRAP) illegal <= 1'b1;
        end
    end

    // Memory handshake: mem_req stays high until mem_ready is seen with it;
    // the access completes in that cycle and mem_ready without mem_req is ignored.
    always_comb begin
        nxt_st  = cur_st;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = PC_SEL_PLUS4;
        rf_we   = 1'b0;
        wb_sel  = WB_SEL_ALU;
        case (cur_st)
            ST_FETCH: begin
                if (!boot_q) begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we  = 1'b1;
                        pc_we  = 1'b1;
                        nxt_st = ST_DECODE;
                    end
                end
            end
            ST_DECODE: nxt_st = legal ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                if (is_load || is_store) begin
                    nxt_st = ST_MEM;
                end else if (is_branch) begin
                    pc_we  = br_taken;
                    pc_sel = PC_SEL_ALU;
                    nxt_st = ST_FETCH;
                end else begin
                    if (is_jump) begin
                        pc_we  = 1'b1;
                        pc_sel = PC_SEL_ALU;
                    end
                    nxt_st = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ready) nxt_st = is_store ? ST_FETCH : ST_WB;
            end
            ST_WB: begin
                rf_we  = (instr[11:7] != 5'd0);
                wb_sel = is_load ? WB_SEL_LOAD : (is_jump ? WB_SEL_PC4 : WB_SEL_ALU);
                nxt_st = ST_FETCH;
            end
            ST_TRAP: begin
                pc_we  = 1'b1;
                pc_sel = PC_SEL_TRAP;
                nxt_st = ST_FETCH;
            end
            default: nxt_st = ST_FETCH;
        endcase
    end

`ifdef MC_CONTROL_INSTRET_EN
    logic retire;

    assign retire = (cur_st == ST_WB)
                 || (cur_st == ST_MEM && mem_ready && is_store)
                 || (cur_st == ST_EXEC && is_branch);

    always_ff @(posedge clk) begin
        if (!rst_n)      instret <= 32'd0;
        else if (retire) instret <= instret + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks ALU, load, branch, jump, store and
// illegal-opcode sequences plus a reset in the middle of a store access.
module tb_mc_control;
    import mc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        br_taken;
    logic        mem_req, mem_we, ir_we, pc_we;
    logic [1:0]  pc_sel;
    logic        alu_a_sel, alu_b_sel;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_func3;
    logic        alu_sub, alu_sra;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic [2:0]  state;
`ifdef MC_CONTROL_INSTRET_EN
    logic [31:0] instret;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_NOP0  = 32'h00000013;
    localparam logic [31:0] I_LW    = 32'h0000A103;
    localparam logic [31:0] I_SW    = 32'h0020A223;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_JAL   = 32'h010000EF;
    localparam logic [31:0] I_ILL   = 32'h0000007F;

    mc_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .br_taken   (br_taken),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .alu_a_sel  (alu_a_sel),
        .alu_b_sel  (alu_b_sel),
        .alu_opcode (alu_opcode),
        .alu_func3  (alu_func3),
        .alu_sub    (alu_sub),
        .alu_sra    (alu_sra),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .illegal    (illegal),
        .state      (state)
`ifdef MC_CONTROL_INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Checking helpers
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [2:0] st, input logic mreq,
                           input logic mwe, input logic irwe, input logic pcwe, input logic rfwe);
        chk({tag, "_state"},   {29'd0, state},   {29'd0, st});
        chk({tag, "_mem_req"}, {31'd0, mem_req}, {31'd0, mreq});
        chk({tag, "_mem_we"},  {31'd0, mem_we},  {31'd0, mwe});
        chk({tag, "_ir_we"},   {31'd0, ir_we},   {31'd0, irwe});
        chk({tag, "_pc_we"},   {31'd0, pc_we},   {31'd0, pcwe});
        chk({tag, "_rf_we"},   {31'd0, rf_we},   {31'd0, rfwe});
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] exp);
`ifdef MC_CONTROL_INSTRET_EN
        chk({tag, "_instret"}, instret, exp);
`else
        if (exp == 32'hFFFF_FFFF) $display("unreachable %s", tag);
`endif
    endtask

    // Driver timing: inputs change 1 time unit after posedge, outputs sampled at negedge
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string tag, input logic [31:0] ins);
        instr     = ins;
        mem_ready = 1'b1;
        smp(); chk_ctl({tag, "_f"}, ST_FETCH, 1, 0, 1, 1, 0);
        chk({tag, "_f_pc_sel"}, {30'd0, pc_sel}, {30'd0, PC_SEL_PLUS4});
        nxt();
        mem_ready = 1'b0;
        smp(); chk_ctl({tag, "_d"}, ST_DECODE, 0, 0, 0, 0, 0);
        nxt();
    endtask

    task automatic run_addi(input string tag);
        fetch_decode(tag, I_ADDI);
        smp(); chk_ctl({tag, "_e"}, ST_EXEC, 0, 0, 0, 0, 0); nxt();
        smp(); chk_ctl({tag, "_w"}, ST_WB, 0, 0, 0, 0, 1); nxt();
    endtask

    initial begin
        rst_n = 1'b0; instr = 32'd0; mem_ready = 1'b0; br_taken = 1'b0;
        nxt(); nxt();
        rst_n = 1'b1;

        // Reset state; mem_ready without mem_req must not start a fetch
        mem_ready = 1'b1;
        smp(); chk_ctl("rst", ST_FETCH, 0, 0, 0, 0, 0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk_cnt("rst", 32'd0);
        nxt();

        // ADDI x1,x0,5
        fetch_decode("addi", I_ADDI);
        smp(); chk_ctl("addi_e", ST_EXEC, 0, 0, 0, 0, 0);
        chk("addi_b_sel", {31'd0, alu_b_sel}, 32'd1);
        chk("addi_a_sel", {31'd0, alu_a_sel}, 32'd0);
        chk("addi_opcode", {25'd0, alu_opcode}, 32'h13);
        nxt();
        smp(); chk_ctl("addi_w", ST_WB, 0, 0, 0, 0, 1);
        chk("addi_wb_sel", {30'd0, wb_sel}, {30'd0, WB_SEL_ALU});
        nxt();

        // LW with three wait cycles in MEM
        fetch_decode("lw", I_LW);
        chk_cnt("lw_start", 32'd1);
        smp(); chk_ctl("lw_e", ST_EXEC, 0, 0, 0, 0, 0);
        chk("lw_func3", {29'd0, alu_func3}, 32'd2);
        nxt();
        for (int i = 0; i < 3; i++) begin
            smp(); chk_ctl("lw_mwait", ST_MEM, 1, 0, 0, 0, 0); nxt();
        end
        mem_ready = 1'b1;
        smp(); chk_ctl("lw_mdone", ST_MEM, 1, 0, 0, 0, 0); nxt();
        mem_ready = 1'b0;
        smp(); chk_ctl("lw_w", ST_WB, 0, 0, 0, 0, 1);
        chk("lw_wb_sel", {30'd0, wb_sel}, {30'd0, WB_SEL_LOAD});
        nxt();

        // BEQ taken, then not taken
        br_taken = 1'b1;
        fetch_decode("beq_t", I_BEQ);
        chk_cnt("beq_t_start", 32'd2);
        smp(); chk_ctl("beq_t_e", ST_EXEC, 0, 0, 0, 1, 0);
        chk("beq_t_pc_sel", {30'd0, pc_sel}, {30'd0, PC_SEL_ALU});
        chk("beq_t_b_sel", {31'd0, alu_b_sel}, 32'd0);
        nxt();
        br_taken = 1'b0;
        fetch_decode("beq_n", I_BEQ);
        smp(); chk_ctl("beq_n_e", ST_EXEC, 0, 0, 0, 0, 0); nxt();

        // JAL x1,16
        fetch_decode("jal", I_JAL);
        chk_cnt("jal_start", 32'd4);
        smp(); chk_ctl("jal_e", ST_EXEC, 0, 0, 0, 1, 0);
        chk("jal_pc_sel", {30'd0, pc_sel}, {30'd0, PC_SEL_ALU});
        chk("jal_a_sel", {31'd0, alu_a_sel}, 32'd1);
        nxt();
        smp(); chk_ctl("jal_w", ST_WB, 0, 0, 0, 0, 1);
        chk("jal_wb_sel", {30'd0, wb_sel}, {30'd0, WB_SEL_PC4});
        nxt();

        // ADDI x0,x0,0: writeback to x0 suppressed
        fetch_decode("nop", I_NOP0);
        smp(); chk_ctl("nop_e", ST_EXEC, 0, 0, 0, 0, 0); nxt();
        smp(); chk_ctl("nop_w", ST_WB, 0, 0, 0, 0, 0); nxt();

        // SW with zero-wait memory
        fetch_decode("sw", I_SW);
        smp(); chk_ctl("sw_e", ST_EXEC, 0, 0, 0, 0, 0); nxt();
        mem_ready = 1'b1;
        smp(); chk_ctl("sw_m", ST_MEM, 1, 1, 0, 0, 0); nxt();

        // Illegal opcode 0x7F
        fetch_decode("ill", I_ILL);
        chk_cnt("ill_start", 32'd7);
        smp(); chk_ctl("ill_trap", ST_TRAP, 0, 0, 0, 1, 0);
        chk("ill_pc_sel", {30'd0, pc_sel}, {30'd0, PC_SEL_TRAP});
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        nxt();
        run_addi("post_ill");
        chk("ill_sticky", {31'd0, illegal}, 32'd1);
        chk_cnt("post_ill", 32'd8);

        // Reset during the MEM phase of a stalled SW
        fetch_decode("swr", I_SW);
        smp(); chk_ctl("swr_e", ST_EXEC, 0, 0, 0, 0, 0); nxt();
        smp(); chk_ctl("swr_m", ST_MEM, 1, 1, 0, 0, 0);
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        smp(); chk_ctl("swr_rst", ST_FETCH, 0, 0, 0, 0, 0);
        chk("swr_rst_illegal", {31'd0, illegal}, 32'd0);
        chk_cnt("swr_rst", 32'd0);
        nxt();
        for (int i = 0; i < 3; i++) run_addi("addi3");
        smp(); chk_cnt("addi3_end", 32'd3);
        chk("addi3_illegal", {31'd0, illegal}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
